// File: rtl/sdr_ref_timer_pkg.sv
// Shared SDRAM timing parameters and refresh-timer state encodings.
// Cycle counts are derived from the controller clock period.
package sdr_ref_timer_pkg;

    localparam int unsigned CLK_PERIOD_NS = 10;

    // Power-up wait and average refresh interval (64 ms / 8192 rows, rounded down).
    localparam int unsigned INIT_WAIT_NS  = 100_000;
    localparam int unsigned REF_PERIOD_NS = 7_800;

    localparam int unsigned INIT_CYCLES_DEF  = INIT_WAIT_NS / CLK_PERIOD_NS;
    localparam int unsigned REF_INTERVAL_DEF = REF_PERIOD_NS / CLK_PERIOD_NS;

    localparam int unsigned T_RP_CYC  = 2;
    localparam int unsigned T_RFC_CYC = 7;

    typedef logic [1:0] tstate_t;

    localparam tstate_t t_INIT = 2'd0;
    localparam tstate_t t_WAIT = 2'd1;
    localparam tstate_t t_RUN  = 2'd2;

endpackage

// File: rtl/sdr_ref_timer_if.sv
// Refresh-timer to command-controller handshake.
// master = timer side, slave = controller side.
interface sdr_ref_timer_if;

    logic       init_done;
    logic       ref_ack;
    logic       delay_100us;
    logic       ref_req;
    logic [3:0] ref_pending;
    logic       ref_overflow;

    modport master (
        input  init_done,
        input  ref_ack,
        output delay_100us,
        output ref_req,
        output ref_pending,
        output ref_overflow
    );

    modport slave (
        output init_done,
        output ref_ack,
        input  delay_100us,
        input  ref_req,
        input  ref_pending,
        input  ref_overflow
    );

endinterface

// File: rtl/sdr_tick_counter.sv
// Wrap counter 0..MODULUS-1 with enable and synchronous clear.
// tc pulses combinationally on the enabled cycle that wraps.
module sdr_tick_counter #(
    parameter int unsigned MODULUS = 10,
    localparam int unsigned W = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tc
);

    logic [W-1:0] count_q;

    always_comb tc = en && (count_q == W'(MODULUS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= tc ? '0 : count_q + W'(1);
        end
    end

endmodule

// File: rtl/sdr_ref_timer.sv
// Power-up wait strobe and periodic auto-refresh request generator with a
// saturating backlog of owed refreshes and a sticky overflow flag.
module sdr_ref_timer
    import sdr_ref_timer_pkg::*;
#(
    parameter int unsigned INIT_CYCLES  = INIT_CYCLES_DEF,
    parameter int unsigned REF_INTERVAL = REF_INTERVAL_DEF,
    parameter int unsigned MAX_PENDING  = 8
) (
    input  logic            clk,
    input  logic            reset,
    sdr_ref_timer_if.master bus
);

    localparam logic [3:0] MAX_P = 4'(MAX_PENDING);

    tstate_t    tstate, tstate_next;
    logic       delay_q, ref_req_q, overflow_q, ack_d;
    logic [3:0] pending_q, pending_next;
    logic       init_tc, tick, run_en, ack_evt, ovf_set;

    assign run_en  = (tstate == t_RUN) && bus.init_done;
    assign ack_evt = bus.ref_ack && !ack_d;

    sdr_tick_counter #(.MODULUS(INIT_CYCLES)) u_init_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (tstate == t_INIT),
        .clr   (1'b0),
        .tc    (init_tc)
    );

    // Held at zero outside an active run so the first tick is a full interval away.
    sdr_tick_counter #(.MODULUS(REF_INTERVAL)) u_ref_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (run_en),
        .clr   (!run_en),
        .tc    (tick)
    );

    always_comb begin
        tstate_next = tstate;
        case (tstate)
            t_INIT:  if (init_tc) tstate_next = t_WAIT;
            t_WAIT:  if (bus.init_done) tstate_next = t_RUN;
            t_RUN:   if (!bus.init_done) tstate_next = t_WAIT;
            default: tstate_next = t_INIT;
        endcase
    end

    always_comb begin
        pending_next = '0;
        ovf_set      = 1'b0;
        if (run_en) begin
            pending_next = pending_q;
            if (tick && !ack_evt) begin
                if (pending_q == MAX_P) begin
                    ovf_set = 1'b1;
                end else begin
                    pending_next = pending_q + 4'd1;
                end
            end else if (ack_evt && !tick && pending_q != 4'd0) begin
                pending_next = pending_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tstate     <= t_INIT;
            delay_q    <= 1'b0;
            ref_req_q  <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            ack_d      <= 1'b0;
        end else begin
            tstate     <= tstate_next;
            ack_d      <= bus.ref_ack;
            pending_q  <= pending_next;
            ref_req_q  <= (pending_next != 4'd0);
            if (tstate == t_INIT && init_tc) delay_q <= 1'b1;
            if (ovf_set) overflow_q <= 1'b1;
        end
    end

    assign bus.delay_100us  = delay_q;
    assign bus.ref_req      = ref_req_q;
    assign bus.ref_pending  = pending_q;
    assign bus.ref_overflow = overflow_q;

endmodule

// File: doc/sdr_ref_timer.md
# sdr_ref_timer

Upstream companion to the SDRAM command controller. Generates the power-up wait strobe (`delay_100us`) that releases the controller's initialization sequence, and the periodic auto-refresh request (`ref_req`) that the controller's command state machine services. Tracks refreshes that are owed but not yet serviced, so bursts that block the controller do not lose refreshes. Flags a sticky error if the backlog exceeds what the SDRAM tolerates.

## Interface
- `INIT_CYCLES`, default 10000: clocks from reset release to `delay_100us` (100 µs at 100 MHz).
- `REF_INTERVAL`, default 780: clocks between refresh ticks (7.8 µs at 100 MHz); must be ≥ 2.
- `MAX_PENDING`, default 8: maximum owed refreshes; must be in 1..15.
- `clk`, input, 1: clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `init_done`, input, 1: from controller; high once initialization is complete.
- `ref_ack`, input, 1: from controller; high for one or more cycles per serviced refresh.
- `delay_100us`, output, 1: power-up wait complete; level, sticky until reset.
- `ref_req`, output, 1: refresh owed; registered, high while pending ≠ 0.
- `ref_pending`, output, 4: number of owed refreshes.
- `ref_overflow`, output, 1: sticky; a tick occurred while pending == `MAX_PENDING`.

## Operation
- The state machine is encoded in a 2-bit `tstate`.
  - `t_INIT`: the init counter increments each cycle. When it reaches `INIT_CYCLES-1`, set `delay_100us` and go to `t_WAIT`.
  - `t_WAIT`: the interval counter is held at 0 and pending is held at 0. Go to `t_RUN` when `init_done` is 1.
  - `t_RUN`: the interval counter counts 0..`REF_INTERVAL-1` and wraps.
    - The wrap cycle is a tick.
    - If `init_done` drops, return to `t_WAIT` and clear the interval counter, pending and `ref_req`. `ref_overflow` is kept.
- Ack detection: register `ref_ack` as `ack_d`. An ack event is `ref_ack & ~ack_d` (rising edge). A multi-cycle ack counts once.
- Pending update in `t_RUN`:
  - tick only: +1, saturating at `MAX_PENDING`.
  - ack only: −1, saturating at 0. An ack at pending 0 is ignored and does not raise an error.
  - tick and ack in the same cycle: unchanged.
- `ref_overflow` is set on a tick with pending == `MAX_PENDING` and no simultaneous ack. It clears only on reset.
- `ref_req` is registered and equals (next pending ≠ 0).
- Counter widths come from `$clog2` of the parameter. No counter exceeds its terminal value.

## Timing
- Reset values: `tstate`=`t_INIT`, all counters 0, `delay_100us`=0, `ref_req`=0, `ref_pending`=0, `ref_overflow`=0, `ack_d`=0.
- `delay_100us` rises on the `INIT_CYCLES`-th rising edge after reset deasserts.
- First tick comes `REF_INTERVAL` cycles after the first cycle in `t_RUN`. `ref_req` and `ref_pending` update on that same edge.
- Ack latency: `ref_pending` decrements on the edge that samples the ack rising edge. `ref_req` falls on that edge if the result is 0.
- Reset mid-operation clears everything asynchronously, including `delay_100us`. The init count restarts from 0.

## Structure
- The shared SDRAM parameter package holds:
  - the `tstate` encodings `t_INIT`, `t_WAIT`, `t_RUN`;
  - the defaults for `INIT_CYCLES` and `REF_INTERVAL`, which are derived from the clock period and tREF, next to the tRP/tRFC cycle constants.
- A single module is sufficient. One sub-module is natural: `sdr_tick_counter`, a parameterised wrap counter with enable, clear and terminal-count pulse. It is instantiated twice, for init and for interval.

## Test plan
- Init strobe: `INIT_CYCLES`=20, release reset → `delay_100us` is 0 through edge 19 and rises on edge 20; `ref_req` stays 0 while `init_done`=0.
- Periodic request: `REF_INTERVAL`=10, `init_done`=1, controller acks 2 cycles after each request with a 3-cycle-wide `ref_ack` → `ref_pending` toggles 0→1→0 every 10 cycles; the wide ack decrements once.
- Backlog: no acks for 35 cycles (`REF_INTERVAL`=10) → `ref_pending`=3 and `ref_req`=1; then 3 separate ack pulses → `ref_pending`=0 and `ref_req`=0.
- Simultaneous: ack rising edge on the tick cycle with pending=2 → pending stays 2.
- Overflow: `MAX_PENDING`=4, no acks for 5 ticks → pending saturates at 4 and `ref_overflow`=1; acks then drain pending to 0 while `ref_overflow` stays 1.
- `init_done` drop with pending=3 → next cycle pending=0 and `ref_req`=0; re-assert `init_done` → first tick after 10 cycles. Mid-run `reset` pulse → all outputs 0 and init wait restarts.
